// File: rtl/ila_capture_engine.sv
// ila_capture_engine: pre-trigger circular capture buffer with per-bit
// edge/level trigger conditioning and an IDLE/PRE/WAIT/POST/DONE sequencer.
// Readback index 0 is always the oldest sample of the captured window.
// Optional feature: define ILA_TIMESTAMP_EN to store a 32-bit cycle
// timestamp alongside every sample (ts_value otherwise reads 0).
module ila_capture_engine #(
  parameter int SIGNAL_W  = 40,
  parameter int TRIGGER_W = 4,
  parameter int BUFFER_W  = 4,
  parameter int DATA_W    = 32,
  localparam int unsigned NSLICE = (SIGNAL_W + DATA_W - 1) / DATA_W,
  localparam int SEL_W = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 i_sample_en,
  input  logic [SIGNAL_W-1:0]  i_signal,
  input  logic [TRIGGER_W-1:0] i_trigger,
  input  logic [TRIGGER_W-1:0] i_trig_mask,
  input  logic [TRIGGER_W-1:0] i_trig_negate,
  input  logic [TRIGGER_W-1:0] i_trig_edge,
  input  logic                 i_reduce_and,
  input  logic [BUFFER_W-1:0]  i_pre_samples,
  input  logic                 i_arm,
  input  logic                 i_abort,
  output logic [2:0]           o_state,
  output logic                 o_triggered,
  output logic [BUFFER_W:0]    o_n_samples,
  input  logic [BUFFER_W-1:0]  i_rd_index,
  input  logic [SEL_W-1:0]     i_rd_sel,
  output logic [DATA_W-1:0]    o_rd_value,
  output logic [31:0]          o_ts_value
);

  localparam int DEPTH = 2 ** BUFFER_W;
  localparam int PADW  = NSLICE * DATA_W;
  localparam logic [BUFFER_W:0] DEPTH_V = (BUFFER_W + 1)'(DEPTH);
  localparam logic [BUFFER_W:0] ONE     = (BUFFER_W + 1)'(1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t                r_state, w_next;
  logic [BUFFER_W-1:0]   r_wp, r_sp, r_pre, w_rdaddr;
  logic [BUFFER_W:0]     r_precnt, r_postcnt, r_nsamp, w_post_len;
  logic [TRIGGER_W-1:0]  r_cprev, w_cond, w_hit;
  logic                  r_triggered, w_fire, w_wr, w_arm_go, w_trig_evt;
  logic [SIGNAL_W-1:0]   r_mem [DEPTH];
  logic [SIGNAL_W-1:0]   r_rdword;
  logic [SEL_W-1:0]      r_rdsel;
  logic [PADW-1:0]       w_pad;
  logic [DATA_W-1:0]     w_slice, r_rd_value;

  // Trigger conditioning; pre_samples is BUFFER_W wide so it can never exceed DEPTH-1
  assign w_cond     = i_trigger ^ i_trig_negate;
  assign w_hit      = w_cond & ~(r_cprev & i_trig_edge);
  assign w_fire     = (i_trig_mask != '0) &&
                      (i_reduce_and ? &(w_hit | ~i_trig_mask) : |(w_hit & i_trig_mask));
  assign w_post_len = DEPTH_V - {1'b0, r_pre};
  assign w_arm_go   = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && i_arm && !i_abort;
  assign w_trig_evt = (r_state == ST_WAIT) && i_sample_en && w_fire && !i_abort;
  assign w_rdaddr   = r_sp + i_rd_index;

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next state and buffer write enable; abort overrides everything
  always_comb begin
    w_next = r_state;
    w_wr   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: if (i_arm) w_next = ST_PRE;
      ST_PRE: begin
        if (r_precnt >= {1'b0, r_pre}) begin
          w_next = ST_WAIT;
        end else if (i_sample_en) begin
          w_wr = 1'b1;
          if (r_precnt + ONE >= {1'b0, r_pre}) w_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_sample_en) begin
          w_wr = 1'b1;
          if (w_fire) w_next = (w_post_len == ONE) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        if (i_sample_en) begin
          w_wr = 1'b1;
          if (r_postcnt + ONE >= w_post_len) w_next = ST_DONE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    if (i_abort) begin
      w_next = ST_IDLE;
      w_wr   = 1'b0;
    end
  end

  // Pointers, counters and trigger history
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wp        <= '0;
      r_sp        <= '0;
      r_pre       <= '0;
      r_precnt    <= '0;
      r_postcnt   <= '0;
      r_nsamp     <= '0;
      r_cprev     <= '0;
      r_triggered <= 1'b0;
    end else begin
      if (i_sample_en) r_cprev <= w_cond;
      if (w_arm_go) begin
        r_wp        <= '0;
        r_sp        <= '0;
        r_precnt    <= '0;
        r_postcnt   <= '0;
        r_nsamp     <= '0;
        r_triggered <= 1'b0;
        r_pre       <= i_pre_samples;
      end
      if (w_wr) begin
        r_wp <= r_wp + BUFFER_W'(1);
        if (r_nsamp != DEPTH_V)   r_nsamp   <= r_nsamp + ONE;
        if (r_state == ST_PRE)    r_precnt  <= r_precnt + ONE;
        if (r_state == ST_POST)   r_postcnt <= r_postcnt + ONE;
      end
      // Window start lands pre_samples behind the trigger sample; trigger counts as post sample 1
      if (w_trig_evt) begin
        r_sp        <= r_wp - r_pre;
        r_triggered <= 1'b1;
        r_postcnt   <= ONE;
      end
    end
  end

  // Sample storage
  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_wp] <= i_signal;
  end

  // Zero-padded slice select of the RAM output word
  always_comb begin
    w_pad = '0;
    w_pad[SIGNAL_W-1:0] = r_rdword;
    w_slice = '0;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (r_rdsel == SEL_W'(i)) w_slice = w_pad[i*DATA_W +: DATA_W];
    end
  end

  // Two-stage readback: synchronous RAM read, then registered slice
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rdword   <= '0;
      r_rdsel    <= '0;
      r_rd_value <= '0;
    end else begin
      r_rdword   <= r_mem[w_rdaddr];
      r_rdsel    <= i_rd_sel;
      r_rd_value <= w_slice;
    end
  end

  assign o_state     = r_state;
  assign o_triggered = r_triggered;
  assign o_n_samples = r_nsamp;
  assign o_rd_value  = r_rd_value;

`ifdef ILA_TIMESTAMP_EN
  logic [31:0] r_ts_cnt, r_ts_rd, r_ts_value;
  logic [31:0] r_ts_mem [DEPTH];

  // Free-running timestamp, restarted by an accepted arm
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           r_ts_cnt <= '0;
    else if (w_arm_go) r_ts_cnt <= '0;
    else               r_ts_cnt <= r_ts_cnt + 32'd1;
  end

  // Timestamp storage alongside each sample
  always_ff @(posedge CLK) begin
    if (w_wr) r_ts_mem[r_wp] <= r_ts_cnt;
  end

  // Timestamp readback with the same two-cycle latency as data
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ts_rd    <= '0;
      r_ts_value <= '0;
    end else begin
      r_ts_rd    <= r_ts_mem[w_rdaddr];
      r_ts_value <= r_ts_rd;
    end
  end

  assign o_ts_value = r_ts_value;
`else
  assign o_ts_value = '0;
`endif

endmodule

// File: tb/tb_ila_capture_engine.sv
// Directed bench for ila_capture_engine: main instance at default widths,
// plus a DATA_W=16 instance sharing the stimulus for multi-slice readback.
module tb_ila_capture_engine;

  logic        CLK = 1'b0;
  logic        RST;
  logic        i_sample_en, i_reduce_and, i_arm, i_abort;
  logic [39:0] i_signal;
  logic [3:0]  i_trigger, i_trig_mask, i_trig_negate, i_trig_edge;
  logic [3:0]  i_pre_samples, i_rd_index;
  logic [0:0]  i_rd_sel;
  logic [1:0]  i_rd_sel16;

  logic [2:0]  o_state, o_state16;
  logic        o_triggered, o_triggered16;
  logic [4:0]  o_n_samples, o_n_samples16;
  logic [31:0] o_rd_value, o_ts_value, o_ts_value16;
  logic [15:0] o_rd_value16;

  int n_checks = 0;
  int n_errors = 0;
  logic        use_cnt;
  logic [39:0] cnt, rec;
  logic [31:0] ts1, ts2, tmp;

  always #5 CLK = ~CLK;

  ila_capture_engine #(.SIGNAL_W(40), .TRIGGER_W(4), .BUFFER_W(4), .DATA_W(32)) u_dut (
    .CLK(CLK), .RST(RST), .i_sample_en(i_sample_en), .i_signal(i_signal),
    .i_trigger(i_trigger), .i_trig_mask(i_trig_mask), .i_trig_negate(i_trig_negate),
    .i_trig_edge(i_trig_edge), .i_reduce_and(i_reduce_and), .i_pre_samples(i_pre_samples),
    .i_arm(i_arm), .i_abort(i_abort), .o_state(o_state), .o_triggered(o_triggered),
    .o_n_samples(o_n_samples), .i_rd_index(i_rd_index), .i_rd_sel(i_rd_sel),
    .o_rd_value(o_rd_value), .o_ts_value(o_ts_value));

  ila_capture_engine #(.SIGNAL_W(40), .TRIGGER_W(4), .BUFFER_W(4), .DATA_W(16)) u_dut16 (
    .CLK(CLK), .RST(RST), .i_sample_en(i_sample_en), .i_signal(i_signal),
    .i_trigger(i_trigger), .i_trig_mask(i_trig_mask), .i_trig_negate(i_trig_negate),
    .i_trig_edge(i_trig_edge), .i_reduce_and(i_reduce_and), .i_pre_samples(i_pre_samples),
    .i_arm(i_arm), .i_abort(i_abort), .o_state(o_state16), .o_triggered(o_triggered16),
    .o_n_samples(o_n_samples16), .i_rd_index(i_rd_index), .i_rd_sel(i_rd_sel16),
    .o_rd_value(o_rd_value16), .o_ts_value(o_ts_value16));

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      if (use_cnt) begin
        cnt = cnt + 40'd1;
        i_signal = cnt;
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    RST = 1'b1; i_sample_en = 1'b1; i_reduce_and = 1'b0; i_arm = 1'b0; i_abort = 1'b0;
    i_trigger = '0; i_trig_mask = 4'b0001; i_trig_negate = '0; i_trig_edge = '0;
    i_pre_samples = 4'd4; i_rd_index = '0; i_rd_sel = '0; i_rd_sel16 = '0;
    use_cnt = 1'b1; cnt = '0; i_signal = '0;

    // reset values
    step(2);
    check("rst_state", o_state, 0);
    check("rst_triggered", o_triggered, 0);
    check("rst_nsamp", o_n_samples, 0);
    check("rst_rd", o_rd_value, 0);
    check("rst_ts", o_ts_value, 0);
    RST = 1'b0;
    step(1);

    // level trigger, OR reduction, window split across wrap
    i_arm = 1'b1; step(1); i_arm = 1'b0;
    check("t1_pre", o_state, 1);
    step(4);
    check("t1_wait", o_state, 2);
    check("t1_nsamp4", o_n_samples, 4);
    step(15);
    check("t1_still_wait", o_state, 2);
    check("t1_not_trig", o_triggered, 0);
    check("t1_nsamp_sat", o_n_samples, 16);
    rec = i_signal; i_trigger = 4'b0001; step(1); i_trigger = '0;
    check("t1_post", o_state, 3);
    check("t1_triggered", o_triggered, 1);
    step(10);
    check("t1_post_last", o_state, 3);
    step(1);
    check("t1_done", o_state, 4);
    check("t1_done_nsamp", o_n_samples, 16);
    i_rd_index = 4'd4; step(2);
    check("t1_rd_trig", o_rd_value, rec[31:0]);
    i_rd_index = 4'd0; step(2);
    tmp = rec[31:0] - 32'd4;
    check("t1_rd_oldest", o_rd_value, tmp);
    i_rd_index = 4'd15; step(2);
    tmp = rec[31:0] + 32'd11;
    check("t1_rd_newest", o_rd_value, tmp);

    // edge mode: held-high trigger never fires, rising edge fires
    i_trig_edge = 4'b0001; i_trigger = 4'b0001; step(1);
    i_arm = 1'b1; step(1); i_arm = 1'b0;
    step(14);
    check("t2_held_high", o_state, 2);
    i_trigger = '0; step(1);
    check("t2_low", o_state, 2);
    rec = i_signal; i_trigger = 4'b0001; step(1);
    check("t2_rise", o_state, 3);
    step(11);
    check("t2_done", o_state, 4);
    i_rd_index = 4'd4; step(2);
    check("t2_rd_trig", o_rd_value, rec[31:0]);

    // AND reduction with negation, then abort retention
    i_trig_edge = '0; i_trig_mask = 4'b0011; i_trig_negate = 4'b0010;
    i_reduce_and = 1'b1; i_trigger = 4'b0011;
    i_arm = 1'b1; step(1); i_arm = 1'b0;
    step(9);
    check("t3_and_11", o_state, 2);
    i_trigger = 4'b0001; step(1);
    check("t3_and_01", o_state, 3);
    i_trigger = '0; i_abort = 1'b1; step(1); i_abort = 1'b0;
    check("t3_abort_state", o_state, 0);
    check("t3_abort_trig", o_triggered, 1);
    check("t3_abort_nsamp", o_n_samples, 10);

    // empty mask never fires under either reduction
    i_trig_mask = '0; i_trig_negate = '0; i_trigger = 4'b1111;
    i_arm = 1'b1; step(1); i_arm = 1'b0;
    step(10);
    check("t3_mask0_and", o_state, 2);
    i_reduce_and = 1'b0; step(3);
    check("t3_mask0_or", o_state, 2);

    // abort beats arm
    i_abort = 1'b1; i_arm = 1'b1; step(1); i_abort = 1'b0; i_arm = 1'b0;
    check("t4_abort_arm", o_state, 0);

    // arm in POST ignored
    i_trig_mask = 4'b0001; i_trigger = '0; i_pre_samples = 4'd4;
    i_arm = 1'b1; step(1); i_arm = 1'b0;
    step(4);
    check("t4_wait", o_state, 2);
    i_trigger = 4'b0001; step(1); i_trigger = '0;
    check("t4_post", o_state, 3);
    i_arm = 1'b1; step(1); i_arm = 1'b0;
    check("t4_arm_in_post", o_state, 3);
    step(9);
    check("t4_post_last", o_state, 3);
    step(1);
    check("t4_post_done", o_state, 4);

    // pre_samples=15: single post-trigger sample
    i_pre_samples = 4'd15;
    i_arm = 1'b1; step(1); i_arm = 1'b0;
    step(14);
    check("t4_pre15_pre", o_state, 1);
    step(1);
    check("t4_pre15_wait", o_state, 2);
    step(3);
    rec = i_signal; i_trigger = 4'b0001; step(1); i_trigger = '0;
    check("t4_pre15_done", o_state, 4);
    check("t4_pre15_nsamp", o_n_samples, 16);
    i_rd_index = 4'd15; step(2);
    check("t4_pre15_rd15", o_rd_value, rec[31:0]);
    i_rd_index = 4'd0; step(2);
    tmp = rec[31:0] - 32'd15;
    check("t4_pre15_rd0", o_rd_value, tmp);

    // asynchronous reset during POST
    i_pre_samples = 4'd4;
    i_arm = 1'b1; step(1); i_arm = 1'b0;
    step(5);
    i_trigger = 4'b0001; step(1); i_trigger = '0;
    check("t4_rst_post", o_state, 3);
    #2; RST = 1'b1; #1;
    check("t4_rst_state", o_state, 0);
    check("t4_rst_trig", o_triggered, 0);
    check("t4_rst_nsamp", o_n_samples, 0);
    check("t4_rst_rd", o_rd_value, 0);
    check("t4_rst_ts", o_ts_value, 0);
    step(1); RST = 1'b0; step(1);

    // slice readback, pre_samples=0 passes PRE without writing
    use_cnt = 1'b0; i_signal = 40'hAB_1234_5678; i_pre_samples = 4'd0;
    i_arm = 1'b1; step(1); i_arm = 1'b0;
    check("t5_pre0", o_state, 1);
    step(1);
    check("t5_pre0_wait", o_state, 2);
    check("t5_pre0_nowrite", o_n_samples, 0);
    i_trigger = 4'b0001; step(1); i_trigger = '0;
    check("t5_post", o_state, 3);
    step(15);
    check("t5_done", o_state, 4);
    i_rd_index = 4'd0; i_rd_sel = 1'b0; i_rd_sel16 = 2'd0; step(2);
    check("t5_sel0", o_rd_value, 32'h1234_5678);
    check("t5_sel0_16", o_rd_value16, 16'h5678);
    i_rd_sel = 1'b1; i_rd_sel16 = 2'd2; step(1);
    check("t5_latency", o_rd_value, 32'h1234_5678);
    step(1);
    check("t5_sel1", o_rd_value, 32'h0000_00AB);
    check("t5_sel2_16", o_rd_value16, 16'h00AB);
    i_rd_sel16 = 2'd1; step(2);
    check("t5_sel1_16", o_rd_value16, 16'h1234);
    i_rd_sel16 = 2'd3; step(2);
    check("t5_sel3_16_zero", o_rd_value16, 16'h0000);

    // timestamps with a sample strobe every third cycle
    use_cnt = 1'b1; i_pre_samples = 4'd4; i_sample_en = 1'b0;
    i_arm = 1'b1; step(1); i_arm = 1'b0;
    for (int k = 0; k < 6; k++) begin
      i_sample_en = 1'b1; step(1);
      i_sample_en = 1'b0; step(2);
    end
    i_rd_index = 4'd1; step(2); ts1 = o_ts_value;
    i_rd_index = 4'd2; step(2); ts2 = o_ts_value;
`ifdef ILA_TIMESTAMP_EN
    tmp = ts2 - ts1;
    check("t6_ts_delta", tmp, 32'd3);
`else
    check("t6_ts1_zero", ts1, 32'd0);
    check("t6_ts2_zero", ts2, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
